// File: rtl/dual_issue_pkg.sv
// Shared types and constants for the dual-issue decode interlock.
// Holds the mult/div state enum, the register-zero constant and a source matcher.
package dual_issue_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned MD_LATENCY_DEF = 32;

  function automatic logic src_match(
    input logic       use_f,
    input logic [4:0] r,
    input logic [4:0] d
  );
    return use_f && (r != REG_ZERO) && (r == d);
  endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Busy/countdown tracker for the single shared mult/div unit.
// Owns the FSM, the countdown and the in-flight destination register.
module md_scoreboard
  import dual_issue_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       md_issue,
  input  logic [4:0] md_issue_rd,
  output logic       md_busy,
  output logic       md_struct,
  output logic [4:0] md_rd,
  output logic       md_wb
);

  localparam int unsigned CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      rd_q    <= REG_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      MD_IDLE: begin
        if (md_issue) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = md_issue_rd;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: begin
        // back-to-back: a new op may claim the unit in its writeback cycle
        if (md_issue) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = md_issue_rd;
        end else begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          rd_d    = REG_ZERO;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
        rd_d    = REG_ZERO;
      end
    endcase
  end

  assign md_busy   = (state_q != MD_IDLE);
  assign md_struct = (state_q == MD_BUSY);
  assign md_wb     = (state_q == MD_DONE);
  assign md_rd     = rd_q;

endmodule

// File: rtl/dual_issue_interlock.sv
// Decode-stage interlock deciding how many FD instructions enter DX.
// Define INTERLOCK_PERF_CNT_EN to add stall_cycles/split_cycles counters.
module dual_issue_interlock
  import dual_issue_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       valid_1,
  input  logic       valid_2,
  input  logic [4:0] rs_1,
  input  logic [4:0] rt_1,
  input  logic [4:0] rd_1,
  input  logic [4:0] rs_2,
  input  logic [4:0] rt_2,
  input  logic [4:0] rd_2,
  input  logic       use_rs_1,
  input  logic       use_rt_1,
  input  logic       use_rs_2,
  input  logic       use_rt_2,
  input  logic       wr_1,
  input  logic       wr_2,
  input  logic       md_1,
  input  logic       md_2,
  input  logic       DX_memToReg_1,
  input  logic       DX_memToReg_2,
  input  logic [4:0] DX_rd_1,
  input  logic [4:0] DX_rd_2,
  output logic       issue_1,
  output logic       issue_2,
  output logic [1:0] issue_count,
  output logic       md_busy,
  output logic [4:0] md_rd,
  output logic       md_wb
`ifdef INTERLOCK_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] split_cycles
`endif
);

  logic       md_struct;
  logic       md_issue;
  logic [4:0] md_issue_rd;
  logic       lu_1, lu_2;
  logic       mp_1, mp_2;
  logic       raw_2;
  logic       blocked_1, blocked_2;

  always_comb begin
    lu_1 = (DX_memToReg_1 &&
             (src_match(use_rs_1, rs_1, DX_rd_1) ||
              src_match(use_rt_1, rt_1, DX_rd_1))) ||
           (DX_memToReg_2 &&
             (src_match(use_rs_1, rs_1, DX_rd_2) ||
              src_match(use_rt_1, rt_1, DX_rd_2)));
    lu_2 = (DX_memToReg_1 &&
             (src_match(use_rs_2, rs_2, DX_rd_1) ||
              src_match(use_rt_2, rt_2, DX_rd_1))) ||
           (DX_memToReg_2 &&
             (src_match(use_rs_2, rs_2, DX_rd_2) ||
              src_match(use_rt_2, rt_2, DX_rd_2)));
    // md_rd of zero never matches: src_match rejects r0
    mp_1 = md_busy &&
           (src_match(use_rs_1, rs_1, md_rd) ||
            src_match(use_rt_1, rt_1, md_rd) ||
            src_match(wr_1, rd_1, md_rd));
    mp_2 = md_busy &&
           (src_match(use_rs_2, rs_2, md_rd) ||
            src_match(use_rt_2, rt_2, md_rd) ||
            src_match(wr_2, rd_2, md_rd));
    raw_2 = valid_1 && wr_1 && (rd_1 != REG_ZERO) &&
            (src_match(use_rs_2, rs_2, rd_1) ||
             src_match(use_rt_2, rt_2, rd_1) ||
             src_match(wr_2, rd_2, rd_1));
    blocked_1 = lu_1 || mp_1 || (md_1 && md_struct);
    blocked_2 = lu_2 || mp_2 || (md_2 && md_struct) ||
                raw_2 || (md_1 && md_2) ||
                !valid_1 || blocked_1;
  end

  assign issue_1 = reset_n && valid_1 && !flush && !blocked_1;
  assign issue_2 = reset_n && valid_2 && !flush && !blocked_2;
  assign issue_count = {1'b0, issue_1} + {1'b0, issue_2};

  assign md_issue    = (issue_1 && md_1) || (issue_2 && md_2);
  assign md_issue_rd = (issue_1 && md_1) ? rd_1 : rd_2;

  md_scoreboard #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md (
    .clock       (clock),
    .reset_n     (reset_n),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .md_busy     (md_busy),
    .md_struct   (md_struct),
    .md_rd       (md_rd),
    .md_wb       (md_wb)
  );

`ifdef INTERLOCK_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] split_q, split_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      split_q <= '0;
    end else begin
      stall_q <= stall_d;
      split_q <= split_d;
    end
  end

  always_comb begin
    stall_d = stall_q;
    split_d = split_q;
    if (valid_1 && !issue_1 && !flush && (stall_q != '1))
      stall_d = stall_q + 32'd1;
    if (issue_1 && valid_2 && !issue_2 && (split_q != '1))
      split_d = split_q + 32'd1;
  end

  assign stall_cycles = stall_q;
  assign split_cycles = split_q;
`endif

endmodule

// File: tb/tb_dual_issue_interlock.sv
// Scoreboard bench for dual_issue_interlock with a cycle-indexed reference.
// Stimulus drives at negedge; a monitor pops expectations 2ns later.
module tb_dual_issue_interlock;

  localparam int L = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic valid_1 = 1'b0, valid_2 = 1'b0;
  logic [4:0] rs_1 = '0, rt_1 = '0, rd_1 = '0;
  logic [4:0] rs_2 = '0, rt_2 = '0, rd_2 = '0;
  logic use_rs_1 = 1'b0, use_rt_1 = 1'b0;
  logic use_rs_2 = 1'b0, use_rt_2 = 1'b0;
  logic wr_1 = 1'b0, wr_2 = 1'b0, md_1 = 1'b0, md_2 = 1'b0;
  logic DX_memToReg_1 = 1'b0, DX_memToReg_2 = 1'b0;
  logic [4:0] DX_rd_1 = '0, DX_rd_2 = '0;
  logic issue_1, issue_2, md_busy, md_wb;
  logic [1:0] issue_count;
  logic [4:0] md_rd;
`ifdef INTERLOCK_PERF_CNT_EN
  logic [31:0] stall_cycles, split_cycles;
`endif

  always #5 clock = ~clock;

  dual_issue_interlock #(.MD_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .valid_1(valid_1), .valid_2(valid_2),
    .rs_1(rs_1), .rt_1(rt_1), .rd_1(rd_1),
    .rs_2(rs_2), .rt_2(rt_2), .rd_2(rd_2),
    .use_rs_1(use_rs_1), .use_rt_1(use_rt_1),
    .use_rs_2(use_rs_2), .use_rt_2(use_rt_2),
    .wr_1(wr_1), .wr_2(wr_2), .md_1(md_1), .md_2(md_2),
    .DX_memToReg_1(DX_memToReg_1), .DX_memToReg_2(DX_memToReg_2),
    .DX_rd_1(DX_rd_1), .DX_rd_2(DX_rd_2),
    .issue_1(issue_1), .issue_2(issue_2),
    .issue_count(issue_count),
    .md_busy(md_busy), .md_rd(md_rd), .md_wb(md_wb)
`ifdef INTERLOCK_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .split_cycles(split_cycles)
`endif
  );

  typedef struct {
    bit v1, v2, fl;
    bit [4:0] rs1, rt1, rd1, rs2, rt2, rd2;
    bit urs1, urt1, urs2, urt2, wr1, wr2, md1, md2, ml1, ml2;
    bit [4:0] dx1, dx2;
  } stim_t;

  typedef struct {
    int cyc;
    bit i1, i2, busy, wb, chk_rd;
    int cnt;
    bit [4:0] mrd;
    int stall, split;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference state: cycle index of the last mult/div issue
  int cyc = 0;
  int md_t = -1000;
  bit [4:0] md_rd_m = '0;
  int stall_m = 0, split_m = 0;

  function automatic bit mt(bit u, bit [4:0] r, bit [4:0] d);
    return u && r != 0 && r == d;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic bit [4:0] rreg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  function automatic stim_t rand_s();
    stim_t s;
    s.v1 = $urandom_range(0, 7) != 0;
    s.v2 = $urandom_range(0, 7) != 0;
    s.fl = $urandom_range(0, 9) == 0;
    s.rs1 = rreg(); s.rt1 = rreg(); s.rd1 = rreg();
    s.rs2 = rreg(); s.rt2 = rreg(); s.rd2 = rreg();
    s.urs1 = 1'($urandom); s.urt1 = 1'($urandom);
    s.urs2 = 1'($urandom); s.urt2 = 1'($urandom);
    s.wr1 = 1'($urandom); s.wr2 = 1'($urandom);
    s.md1 = $urandom_range(0, 7) == 0;
    s.md2 = $urandom_range(0, 7) == 0;
    s.ml1 = $urandom_range(0, 3) == 0;
    s.ml2 = $urandom_range(0, 3) == 0;
    s.dx1 = rreg(); s.dx2 = rreg();
    return s;
  endfunction

  task automatic step(input stim_t s, input bit rst);
    exp_t e;
    bit act, strb, wb, lu1, lu2, mp1, mp2, raw, b1, b2;
    @(negedge clock);
    reset_n = !rst;
    valid_1 = s.v1; valid_2 = s.v2; flush = s.fl;
    rs_1 = s.rs1; rt_1 = s.rt1; rd_1 = s.rd1;
    rs_2 = s.rs2; rt_2 = s.rt2; rd_2 = s.rd2;
    use_rs_1 = s.urs1; use_rt_1 = s.urt1;
    use_rs_2 = s.urs2; use_rt_2 = s.urt2;
    wr_1 = s.wr1; wr_2 = s.wr2; md_1 = s.md1; md_2 = s.md2;
    DX_memToReg_1 = s.ml1; DX_memToReg_2 = s.ml2;
    DX_rd_1 = s.dx1; DX_rd_2 = s.dx2;
    if (rst) begin
      md_t = -1000; md_rd_m = '0; stall_m = 0; split_m = 0;
    end
    act  = cyc >= md_t + 1 && cyc <= md_t + L + 1;
    strb = act && cyc <= md_t + L;
    wb   = act && cyc == md_t + L + 1;
    lu1 = (s.ml1 && (mt(s.urs1, s.rs1, s.dx1) || mt(s.urt1, s.rt1, s.dx1))) ||
          (s.ml2 && (mt(s.urs1, s.rs1, s.dx2) || mt(s.urt1, s.rt1, s.dx2)));
    lu2 = (s.ml1 && (mt(s.urs2, s.rs2, s.dx1) || mt(s.urt2, s.rt2, s.dx1))) ||
          (s.ml2 && (mt(s.urs2, s.rs2, s.dx2) || mt(s.urt2, s.rt2, s.dx2)));
    mp1 = act && (mt(s.urs1, s.rs1, md_rd_m) || mt(s.urt1, s.rt1, md_rd_m) ||
                  mt(s.wr1, s.rd1, md_rd_m));
    mp2 = act && (mt(s.urs2, s.rs2, md_rd_m) || mt(s.urt2, s.rt2, md_rd_m) ||
                  mt(s.wr2, s.rd2, md_rd_m));
    raw = s.v1 && s.wr1 && s.rd1 != 0 &&
          (mt(s.urs2, s.rs2, s.rd1) || mt(s.urt2, s.rt2, s.rd1) ||
           (s.wr2 && s.rd2 == s.rd1));
    b1 = lu1 || mp1 || (s.md1 && strb);
    b2 = lu2 || mp2 || (s.md2 && strb) || raw || (s.md1 && s.md2) ||
         !(s.v1 && !b1);
    e.cyc = cyc;
    e.i1 = !rst && s.v1 && !s.fl && !b1;
    e.i2 = !rst && s.v2 && !s.fl && !b2;
    e.cnt = int'(e.i1) + int'(e.i2);
    e.busy = act;
    e.wb = wb;
    e.chk_rd = act || rst;
    e.mrd = act ? md_rd_m : 5'd0;
    e.stall = stall_m;
    e.split = split_m;
    q.push_back(e);
    if (!rst) begin
      if (e.i1 && s.md1) begin md_t = cyc; md_rd_m = s.rd1; end
      else if (e.i2 && s.md2) begin md_t = cyc; md_rd_m = s.rd2; end
      if (s.v1 && !e.i1 && !s.fl) stall_m++;
      if (e.i1 && s.v2 && !e.i2) split_m++;
    end
    cyc++;
  endtask

  task automatic chk(input string nm, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("issue_1", e.cyc, int'(issue_1), int'(e.i1));
      chk("issue_2", e.cyc, int'(issue_2), int'(e.i2));
      chk("issue_count", e.cyc, int'(issue_count), e.cnt);
      chk("md_busy", e.cyc, int'(md_busy), int'(e.busy));
      chk("md_wb", e.cyc, int'(md_wb), int'(e.wb));
      if (e.chk_rd) chk("md_rd", e.cyc, int'(md_rd), int'(e.mrd));
`ifdef INTERLOCK_PERF_CNT_EN
      chk("stall_cycles", e.cyc, int'(stall_cycles), e.stall);
      chk("split_cycles", e.cyc, int'(split_cycles), e.split);
`endif
    end
  end

  initial begin
    stim_t s;
    step(idle_s(), 1'b1);
    step(idle_s(), 1'b1);
    // load-use, then load gone
    s = idle_s();
    s.v1 = 1; s.rs1 = 5; s.urs1 = 1; s.v2 = 1; s.rs2 = 6; s.urs2 = 1;
    s.ml1 = 1; s.dx1 = 5;
    step(s, 1'b0);
    s.ml1 = 0;
    step(s, 1'b0);
    // intra-bundle RAW and the rd_1=0 variant
    s = idle_s();
    s.v1 = 1; s.wr1 = 1; s.rd1 = 7; s.v2 = 1; s.rt2 = 7; s.urt2 = 1;
    step(s, 1'b0);
    s.rd1 = 0;
    step(s, 1'b0);
    // mult to r9, then a reader of r9 every cycle
    s = idle_s();
    s.v1 = 1; s.md1 = 1; s.wr1 = 1; s.rd1 = 9;
    step(s, 1'b0);
    s = idle_s();
    s.v1 = 1; s.rs1 = 9; s.urs1 = 1;
    for (int i = 0; i < 7; i++) step(s, 1'b0);
    // two mult/divs in one bundle, then a second one in the DONE cycle
    s = idle_s();
    s.v1 = 1; s.md1 = 1; s.wr1 = 1; s.rd1 = 3;
    s.v2 = 1; s.md2 = 1; s.wr2 = 1; s.rd2 = 4;
    step(s, 1'b0);
    s = idle_s();
    s.v1 = 1; s.md1 = 1; s.wr1 = 1; s.rd1 = 10;
    for (int i = 0; i < 6; i++) step(s, 1'b0);
    for (int i = 0; i < 6; i++) step(idle_s(), 1'b0);
    // reset during BUSY
    s = idle_s();
    s.v1 = 1; s.md1 = 1; s.wr1 = 1; s.rd1 = 9;
    step(s, 1'b0);
    step(idle_s(), 1'b0);
    step(idle_s(), 1'b1);
    s = idle_s();
    s.v1 = 1; s.rs1 = 9; s.urs1 = 1;
    for (int i = 0; i < 7; i++) step(s, 1'b0);
    // flush with a clean bundle
    s = idle_s();
    s.v1 = 1; s.v2 = 1; s.rs1 = 1; s.urs1 = 1; s.rs2 = 2; s.urs2 = 1;
    s.fl = 1;
    step(s, 1'b0);
    s.fl = 0;
    step(s, 1'b0);
    for (int i = 0; i < 3000; i++)
      step(rand_s(), $urandom_range(0, 299) == 0);
    @(negedge clock);
    #4;
    chk("drain", cyc, q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_issue_interlock.md
# dual_issue_interlock

Decode-stage interlock for the 2-wide pipeline. Each cycle it decides how many instructions of the FD bundle enter DX: both, slot 1 only, or none. It is the producer side of forwarding: it holds back the hazards the DX-stage bypass network cannot resolve. These are load-use, intra-bundle dependence, and the single shared multi-cycle mult/div unit, which it tracks with a busy/countdown state machine.

## Interface
- `MD_LATENCY`, 32: mult/div busy cycles after issue; legal range ≥2.
- `clock`  in  1  pipeline clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  branch/jump squash of the FD bundle; forces no issue.
- `valid_1`, `valid_2`  in  1  FD slot holds a real instruction.
- `rs_1`, `rt_1`, `rd_1`, `rs_2`, `rt_2`, `rd_2`  in  5  FD register specifiers.
- `use_rs_1`, `use_rt_1`, `use_rs_2`, `use_rt_2`  in  1  slot reads that source.
- `wr_1`, `wr_2`  in  1  slot writes `rd_k`.
- `md_1`, `md_2`  in  1  slot is a mult/div.
- `DX_memToReg_1`, `DX_memToReg_2`  in  1  DX slot is a load.
- `DX_rd_1`, `DX_rd_2`  in  5  DX destinations.
- `issue_1`, `issue_2`  out  1  slot advances to DX this cycle.
- `issue_count`  out  2  number of instructions consumed, 0–2.
- `md_busy`  out  1  mult/div unit occupied (BUSY or DONE).
- `md_rd`  out  5  destination of the in-flight mult/div.
- `md_wb`  out  1  one-cycle pulse: mult/div result written back this cycle.

## Operation
- A source matches when its `use_*` flag is set, its specifier is non-zero, and it equals the destination under test.
- Slot k is blocked by any of the following:
  - Load-use: a source matches `DX_rd_j`, with `DX_memToReg_j` set, for either j.
  - Mult/div pending: `md_busy` is set and a source or `rd_k` (when `wr_k`) matches `md_rd`.
  - Structural: `md_k` is set and the unit is BUSY.
- Slot 2 is additionally blocked when any of these holds:
  - `valid_1`, `wr_1` and `rd_1`≠0, and a slot-2 source or `rd_2` (when `wr_2`) equals `rd_1` (RAW/WAW).
  - `md_1` and `md_2` are both set.
  - Slot 1 is blocked or invalid. Issue is strictly in order.
- Issue signals:
  - `issue_1` = `valid_1` & !flush & !blocked_1.
  - `issue_2` = `valid_2` & !flush & !blocked_2.
  - `issue_count` = `issue_1` + `issue_2`.
- Mult/div FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY on an issued mult/div. The counter loads MD_LATENCY−1 and `md_rd` captures that slot's rd.
  - BUSY: the counter decrements each cycle. BUSY→DONE when the counter is 0.
  - DONE: `md_wb`=1 for exactly one cycle.
  - DONE→IDLE, or DONE→BUSY if a new mult/div issues in the DONE cycle. In DONE, `md_k` is not structurally blocked, but register matches against `md_rd` still block.
- `md_rd`=0: the unit is still occupied; no register hazard arises.
- `flush` does not abort an in-flight mult/div.
- Counter width is $clog2(MD_LATENCY).

## Timing
- Issue outputs are combinational from the current inputs and state. There is zero latency.
- Mult/div issued in cycle T:
  - BUSY during T+1 … T+MD_LATENCY.
  - DONE (`md_wb`) at T+MD_LATENCY+1.
  - A dependent instruction issues no earlier than T+MD_LATENCY+2.
- A load-use stall lasts exactly one cycle when the load is the only hazard.
- Reset (asynchronous, any state, including mid-BUSY):
  - State goes to IDLE; counter=0, `md_rd`=0, `md_busy`=0, `md_wb`=0.
  - No pending `md_wb` is emitted after reset.
- While `reset_n` is low: `issue_1`=`issue_2`=0 and `issue_count`=0.

## Configuration
- `INTERLOCK_PERF_CNT_EN` defined: adds two 32-bit outputs.
  - `stall_cycles` counts cycles with `valid_1` & !`issue_1` & !`flush`.
  - `split_cycles` counts cycles with `issue_1` & `valid_2` & !`issue_2`.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and registers are absent. Issue behaviour is identical.

## Structure
- The shared package `dual_issue_pkg` holds:
  - the mult/div state enum (IDLE/BUSY/DONE);
  - the register-zero constant;
  - the default MD_LATENCY.
- Sub-module `md_scoreboard` holds the FSM, the counter and `md_rd`; it drives `md_busy`, `md_rd` and `md_wb`.
- The top level holds the comparators, the blocking logic and the optional perf counters.

## Test plan
- DX_memToReg_1=1, DX_rd_1=5; slot-1 rs=5 → cycle 0: `issue_count`=0. Next cycle, with the load gone from DX: `issue_count`=2.
- Slot 1: wr_1=1, rd_1=7. Slot 2: rt_2=7, use_rt_2=1 → `issue_1`=1, `issue_2`=0, `issue_count`=1. The same with rd_1=0 → `issue_count`=2.
- MD_LATENCY=4; mult to r9 issued at T; slot-1 reads r9 every cycle → `md_busy` during T+1…T+5; `md_wb`=1 only at T+5; `issue_1`=1 first at T+6.
- md_1=md_2=1 in IDLE → `issue_1`=1, `issue_2`=0. A second mult/div arriving in the DONE cycle issues and re-enters BUSY.
- reset_n pulsed low during BUSY → `md_busy`=0 and `md_rd`=0 immediately; no `md_wb` afterwards; a dependent instruction issues the first cycle after release.
- `flush`=1 with both slots valid and hazard-free → `issue_count`=0. With `INTERLOCK_PERF_CNT_EN`, `stall_cycles` is unchanged.
